instr_fetch: RTL and testbench

//  Upstream fetch stage for the 8-bit CPU control FSM. Owns the program counter.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_reg.sv | 20 ++
 rtl/instr_fetch.sv | 80 ++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode field encodings and fetch-stage states.
package cpu_pkg;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        REDIR,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: sync reset to RESET_PC, jump load wins over increment, wraps modulo 2^ADDR_W.
module pc_reg #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst)       pc <= RESET_PC;
        else if (load) pc <= load_val;
        else if (inc)  pc <= pc + ADDR_W'(1);
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads program memory over req/valid, and hands bytes
// to the control FSM over valid/ready. Parks in HALT after a STOP is consumed.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halt
);

    fetch_state_t state, state_nxt;
    logic         fire;
    logic         consume;

    // A redirect in the same cycle as returning data throws that data away.
    assign fire    = (state == REQ) && mem_valid && !jump_en;
    assign consume = instr_valid && instr_ready;

    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (jump_en),
        .load_val (jump_addr),
        .inc      (fire),
        .pc       (pc)
    );

    assign mem_req  = (state == REQ);
    assign mem_addr = pc;
    assign halt     = (state == HALT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (mem_valid) state_nxt = HOLD;
            HOLD:    if (consume)
                         state_nxt = (instr[DATA_W-1:DATA_W-2] == OP_STOP) ? HALT : REQ;
            REDIR:   state_nxt = REQ;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
        // Redirect overrides everything, including a STOP being consumed this cycle.
        if (jump_en) state_nxt = REDIR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                instr       <= mem_rdata;
                instr_valid <= 1'b1;
            end else if (jump_en || consume) begin
                instr_valid <= 1'b0;
            end
        end
    end

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        mem_req |=> (!mem_req || $stable(mem_addr)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural program memory of programmable wait.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_valid;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic [7:0] pc;
    logic       halt;

    logic [7:0] mem [256];
    int         mem_wait;
    int         wait_cnt;
    logic       force_valid;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // Memory returns data once mem_req has been held for mem_wait cycles.
    assign mem_valid = (mem_req && (wait_cnt >= mem_wait)) || force_valid;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_req || mem_valid) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    instr_fetch #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .halt        (halt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"},    pc,          8'h00);
        chk({tag, ".req"},   mem_req,     1'b0);
        chk({tag, ".instr"}, instr,       8'h00);
        chk({tag, ".vld"},   instr_valid, 1'b0);
        chk({tag, ".halt"},  halt,        1'b0);
    endtask

    logic [7:0] prog [3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h40;
        mem[8'h00] = 8'h41; mem[8'h01] = 8'h82; mem[8'h02] = 8'h00;
        mem[8'h10] = 8'h55; mem[8'h11] = 8'h96;
        mem[8'hFF] = 8'hC3; mem[8'h20] = 8'h00;
        prog[0] = 8'h41; prog[1] = 8'h82; prog[2] = 8'h00;

        rst = 1'b1; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
        mem_wait = 0; force_valid = 1'b0;
        tick(); tick();
        chk_reset("rst");

        // 1: zero-wait stream ending in STOP
        rst = 1'b0; instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1.req",  mem_req,  1'b1);
            chk("t1.addr", mem_addr, 8'(k));
            tick();
            chk("t1.vld",   instr_valid, 1'b1);
            chk("t1.instr", instr,       prog[k]);
            chk("t1.pc",    pc,          8'(k + 1));
            chk("t1.noreq", mem_req,     1'b0);
        end
        tick();
        chk("t1.halt", halt,        1'b1);
        chk("t1.vld0", instr_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1.parked", {halt, mem_req}, 2'b10);
        end

        // 5: jump out of HALT
        jump_en = 1'b1; jump_addr = 8'h10;
        tick();
        jump_en = 1'b0;
        chk("t5.halt", halt,    1'b0);
        chk("t5.redir", mem_req, 1'b0);
        chk("t5.pc",   pc,      8'h10);
        tick();
        chk("t5.req",  {mem_req, mem_addr}, {1'b1, 8'h10});
        instr_ready = 1'b0;
        tick();
        chk("t5.instr", instr, 8'h55);
        chk("t5.pc1",   pc,    8'h11);

        // 2: ready low 4 cycles, then 3-cycle memory wait
        mem_wait = 3;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2.hold", {instr_valid, instr, pc, mem_req}, {1'b1, 8'h55, 8'h11, 1'b0});
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2.wait", {mem_req, mem_addr, pc, instr_valid}, {1'b1, 8'h11, 8'h11, 1'b0});
        end
        tick();
        chk("t2.instr", {instr_valid, instr, pc}, {1'b1, 8'h96, 8'h12});

        // 3: PC wraps from FF to 00
        mem_wait = 0;
        jump_en = 1'b1; jump_addr = 8'hFF;
        tick();
        jump_en = 1'b0;
        chk("t3.redir", {mem_req, instr_valid, pc}, {1'b0, 1'b0, 8'hFF});
        tick();
        chk("t3.req", {mem_req, mem_addr}, {1'b1, 8'hFF});
        tick();
        chk("t3.wrap", {instr, pc}, {8'hC3, 8'h00});
        tick();
        chk("t3.next", {mem_req, mem_addr}, {1'b1, 8'h00});

        // 4: jump during REQ with data arriving the same cycle
        chk("t4.mv", mem_valid, 1'b1);
        jump_en = 1'b1; jump_addr = 8'h20;
        tick();
        jump_en = 1'b0;
        chk("t4.redir", {mem_req, instr_valid, instr, pc}, {1'b0, 1'b0, 8'hC3, 8'h20});
        tick();
        chk("t4.req", {mem_req, mem_addr}, {1'b1, 8'h20});
        instr_ready = 1'b0;
        tick();
        chk("t4.stop", {instr_valid, instr, pc}, {1'b1, 8'h00, 8'h21});

        // jump together with consuming a STOP: redirect wins, no HALT
        instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 8'h30;
        tick();
        jump_en = 1'b0;
        chk("jstop.redir", {halt, instr_valid, mem_req, pc}, {1'b0, 1'b0, 1'b0, 8'h30});
        tick();
        chk("jstop.req", {halt, mem_req, mem_addr}, {1'b0, 1'b1, 8'h30});

        // 6: reset during REQ, late valid ignored, reset during HOLD
        rst = 1'b1;
        tick();
        chk_reset("t6a");
        rst = 1'b0; force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        chk("t6.late", {instr_valid, instr, pc}, {1'b0, 8'h00, 8'h00});
        chk("t6.req",  {mem_req, mem_addr}, {1'b1, 8'h00});
        instr_ready = 1'b0;
        tick();
        chk("t6.hold", {instr_valid, instr, pc}, {1'b1, 8'h41, 8'h01});
        rst = 1'b1;
        tick();
        chk_reset("t6b");
        rst = 1'b0;
        tick();
        chk("t6.restart", {mem_req, mem_addr}, {1'b1, 8'h00});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
